bitmap_xfer_ctrl: RTL and testbench
===================================

BITMAP_XFER_CTRL -- requirements
Module: bitmap_xfer_ctrl

Interface
REQ-001 Parameter WORDS, 96, number of 16-bit memory words per bitmap (1536/16).
REQ-002 Parameter AW, 16, data-memory address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start_ldb  in  1  one-cycle request: load a bitmap from memory into the bitmap register.
REQ-006 start_stb  in  1  one-cycle request: store a bitmap register to memory.
REQ-007 bm_sel  in  2  target/source bitmap register index.
REQ-008 base_addr  in  AW  first memory word address.
REQ-009 rbm_data  in  1536  bitmap register read data for STB.
REQ-010 mem_rdata  in  16  memory read data, valid one cycle after the read is issued.
REQ-011 mem_en  out  1  memory access enable.
REQ-012 mem_we  out  1  memory write enable.
REQ-013 mem_addr  out  AW  memory address.
REQ-014 mem_wdata  out  16  memory write data.
REQ-015 wbm_en  out  1  bitmap register write enable.
REQ-016 wbm_addr  out  2  bitmap register write index.
REQ-017 wbm_data  out  1536  bitmap register write data.
REQ-018 busy  out  1  pipeline stall request; high while a transfer is in progress.
REQ-019 done  out  1  one-cycle completion pulse.

Function
REQ-020 States: IDLE, LD_RUN, LD_LAST, LD_COMMIT, ST_RUN, ST_DONE; 7-bit word counter k.
REQ-021 In IDLE, a start sampled on a clock edge latches bm_sel and base_addr and clears k.
REQ-022 When start_ldb and start_stb are both high in IDLE, the load is taken and the store is dropped.
REQ-023 Starts arriving in any state other than IDLE are ignored, with no queuing.
REQ-024 busy is high in every state except IDLE and is registered.
REQ-025 LD_RUN: mem_en=1, mem_we=0, mem_addr=base+k; k increments each cycle; after the cycle with k=WORDS-1, the block goes to LD_LAST.
REQ-026 Word returned for index k is written into assembly buffer bits [16k+15:16k] in the cycle after issue; LD_LAST captures word WORDS-1 with mem_en=0.
REQ-027 LD_COMMIT: wbm_en=1, wbm_addr=latched bm_sel, wbm_data=buffer, done=1 for exactly one cycle; the block then returns to IDLE.
REQ-028 On a start_stb accept, rbm_data is snapshotted into the buffer on the same edge; later changes to rbm_data have no effect.
REQ-029 ST_RUN: mem_en=1, mem_we=1, mem_addr=base+k, mem_wdata=buffer[16k+15:16k]; after k=WORDS-1 the block goes to ST_DONE.
REQ-030 ST_DONE: done=1 for one cycle with mem_en=0, then IDLE; wbm_en stays 0 throughout a store.
REQ-031 Address arithmetic is modulo 2^AW; base+k wraps past 0xFFFF to 0x0000 with no error.
REQ-032 Latency: accept edge T; load done/wbm_en at cycle T+WORDS+2; store done at cycle T+WORDS+1.
REQ-033 Outside the active states, mem_en, mem_we, wbm_en and done are 0; mem_addr, mem_wdata and wbm_data are don't-care but held stable.

Reset
REQ-034 rst_n low forces IDLE, k=0, latched bm_sel=0, latched base=0, buffer=0, and all outputs 0, asynchronously.
REQ-035 Reset mid-transfer aborts the operation: no wbm_en and no done are issued, and partially stored memory words are not rolled back.
REQ-036 After rst_n deasserts, the first start is accepted on the first rising edge at which it is sampled.

Verification
REQ-037 LDB with bm_sel=2, base=0x0100, memory word i=i: reads 0x0100..0x015F; at T+98 wbm_en=1, wbm_addr=2, wbm_data[15:0]=0, wbm_data[1535:1520]=0x005F, done=1.
REQ-038 STB with bm_sel=1, base=0x0200, rbm_data pattern word k=0xA500+k, rbm_data altered at T+5: writes 0x0200..0x025F with 0xA500..0xA55F; done at T+97.
REQ-039 start_ldb and start_stb both high in IDLE: only the load runs and mem_we stays 0; start_stb pulsed at T+10: ignored.
REQ-040 LDB with base=0xFFF0: addresses 0xFFF0..0xFFFF then 0x0000..0x004F.
REQ-041 rst_n low at T+40 during LDB: outputs 0 immediately, no wbm_en follows; a new LDB after release completes normally.
REQ-042 Back-to-back: STB accepted the cycle after done: busy is low for exactly one IDLE cycle and the second transfer completes correctly.

Source files
------------

// File: rtl/bitmap_xfer_ctrl_if.sv
// Bus bundle between the bitmap transfer controller, its requester, the data memory
// and the bitmap register file.
interface bitmap_xfer_ctrl_if #(
  parameter int WORDS = 96,
  parameter int AW    = 16
);
  logic                  start_ldb;
  logic                  start_stb;
  logic [1:0]            bm_sel;
  logic [AW-1:0]         base_addr;
  logic [WORDS*16-1:0]   rbm_data;
  logic [15:0]           mem_rdata;
  logic                  mem_en;
  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic [15:0]           mem_wdata;
  logic                  wbm_en;
  logic [1:0]            wbm_addr;
  logic [WORDS*16-1:0]   wbm_data;
  logic                  busy;
  logic                  done;

  modport master (
    output start_ldb, start_stb, bm_sel, base_addr, rbm_data, mem_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, wbm_en, wbm_addr, wbm_data, busy, done
  );

  modport slave (
    input  start_ldb, start_stb, bm_sel, base_addr, rbm_data, mem_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, wbm_en, wbm_addr, wbm_data, busy, done
  );
endinterface

// File: rtl/bitmap_xfer_ctrl.sv
// Moves a whole bitmap between a bitmap register and 16-bit data memory, one word per cycle.
// All outputs are registered and computed from the next state so they line up with it.
module bitmap_xfer_ctrl #(
  parameter int WORDS = 96,
  parameter int AW    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  bitmap_xfer_ctrl_if.slave bus
);
  localparam int BW = WORDS * 16;
  localparam logic [6:0] K_LAST = 7'(WORDS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LD_RUN    = 3'd1,
    LD_LAST   = 3'd2,
    LD_COMMIT = 3'd3,
    ST_RUN    = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [6:0]      k_r, k_nxt_s, k_prev_s;
  logic [1:0]      sel_r, sel_nxt_s;
  logic [AW-1:0]   base_r, base_nxt_s;
  logic [BW-1:0]   buf_r, buf_nxt_s, wsrc_s;
  logic            mem_en_r, mem_we_r, wbm_en_r, busy_r, done_r;
  logic            mem_en_nxt_s, mem_we_nxt_s;
  logic [AW-1:0]   mem_addr_r, mem_addr_nxt_s;
  logic [15:0]     mem_wdata_r, mem_wdata_nxt_s;

  assign k_prev_s = k_r - 7'd1;

  // Next-state, word counter, assembly buffer and next output values.
  always_comb begin
    state_nxt_s     = state_r;
    k_nxt_s         = k_r;
    sel_nxt_s       = sel_r;
    base_nxt_s      = base_r;
    buf_nxt_s       = buf_r;
    wsrc_s          = buf_r;
    case (state_r)
      IDLE: begin
        if (bus.start_ldb) begin
          state_nxt_s = LD_RUN;
          k_nxt_s     = 7'd0;
          sel_nxt_s   = bus.bm_sel;
          base_nxt_s  = bus.base_addr;
        end else if (bus.start_stb) begin
          state_nxt_s = ST_RUN;
          k_nxt_s     = 7'd0;
          sel_nxt_s   = bus.bm_sel;
          base_nxt_s  = bus.base_addr;
          buf_nxt_s   = bus.rbm_data;
          wsrc_s      = bus.rbm_data;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LD_RUN: begin
        // Read data lags the issued address by one cycle, so capture word k-1.
        if (k_r != 7'd0) begin
          buf_nxt_s[{k_prev_s, 4'b0000} +: 16] = bus.mem_rdata;
        end else begin
          buf_nxt_s = buf_r;
        end
        if (k_r == K_LAST) begin
          state_nxt_s = LD_LAST;
        end else begin
          k_nxt_s = k_r + 7'd1;
        end
      end
      LD_LAST: begin
        buf_nxt_s[{k_r, 4'b0000} +: 16] = bus.mem_rdata;
        state_nxt_s = LD_COMMIT;
      end
      LD_COMMIT: state_nxt_s = IDLE;
      ST_RUN: begin
        if (k_r == K_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          k_nxt_s = k_r + 7'd1;
        end
      end
      ST_DONE: state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase

    mem_en_nxt_s = (state_nxt_s == LD_RUN) || (state_nxt_s == ST_RUN);
    mem_we_nxt_s = (state_nxt_s == ST_RUN);
    if (mem_en_nxt_s) begin
      mem_addr_nxt_s = base_nxt_s + {{(AW-7){1'b0}}, k_nxt_s};
    end else begin
      mem_addr_nxt_s = mem_addr_r;
    end
    if (state_nxt_s == ST_RUN) begin
      mem_wdata_nxt_s = wsrc_s[{k_nxt_s, 4'b0000} +: 16];
    end else begin
      mem_wdata_nxt_s = mem_wdata_r;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      k_r         <= 7'd0;
      sel_r       <= 2'd0;
      base_r      <= {AW{1'b0}};
      buf_r       <= {BW{1'b0}};
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= 16'h0000;
      wbm_en_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      k_r         <= k_nxt_s;
      sel_r       <= sel_nxt_s;
      base_r      <= base_nxt_s;
      buf_r       <= buf_nxt_s;
      mem_en_r    <= mem_en_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      wbm_en_r    <= (state_nxt_s == LD_COMMIT);
      busy_r      <= (state_nxt_s != IDLE);
      done_r      <= (state_nxt_s == LD_COMMIT) || (state_nxt_s == ST_DONE);
    end
  end

  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.wbm_en    = wbm_en_r;
  assign bus.wbm_addr  = sel_r;
  assign bus.wbm_data  = buf_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
endmodule

// File: tb/tb_bitmap_xfer_ctrl.sv
// Bench for bitmap_xfer_ctrl: a word-addressed memory responder, an event monitor and a
// shadow memory model that predicts every read, write, commit and completion time.
module tb_bitmap_xfer_ctrl;
  localparam int WORDS = 96;
  localparam int BW    = WORDS * 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bitmap_xfer_ctrl_if #(.WORDS(WORDS), .AW(16)) bus ();
  bitmap_xfer_ctrl #(.WORDS(WORDS), .AW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { int s; logic we; logic [15:0] addr; logic [15:0] data; } mem_ev_t;
  typedef struct { int s; logic [1:0] a; logic [BW-1:0] d; } wbm_ev_t;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  mem_ev_t mem_q[$];
  wbm_ev_t wbm_q[$];
  int      done_q[$];
  int cyc = 0;
  int n_checks = 0, n_pass = 0, n_fail = 0;
  logic [BW-1:0] last_wd;

  function automatic logic [15:0] init_word(int i);
    if (i >= 16'h0100 && i < 16'h0160) return 16'(i - 16'h0100);
    return 16'(i) ^ 16'h5A5A;
  endfunction

  // Memory responder: writes land on the edge, read data is valid the following cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_word(i);
    end else begin
      if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  // Monitor; the stamp is the index of the edge that samples this cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.mem_en) mem_q.push_back('{cyc + 1, bus.mem_we, bus.mem_addr, bus.mem_wdata});
      if (bus.wbm_en) wbm_q.push_back('{cyc + 1, bus.wbm_addr, bus.wbm_data});
      if (bus.done) done_q.push_back(cyc + 1);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_bm();
    logic [BW-1:0] v;
    for (int w = 0; w < WORDS; w++) v[16*w +: 16] = 16'($urandom);
    return v;
  endfunction

  function automatic logic [BW-1:0] ref_bitmap(logic [15:0] base);
    logic [BW-1:0] v;
    for (int w = 0; w < WORDS; w++) v[16*w +: 16] = ref_mem[base + 16'(w)];
    return v;
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_op(input bit ld, input bit st, input logic [1:0] sel,
                          input logic [15:0] base, input logic [BW-1:0] rbm, output int t);
    @(negedge clk);
    bus.start_ldb = ld;
    bus.start_stb = st;
    bus.bm_sel    = sel;
    bus.base_addr = base;
    bus.rbm_data  = rbm;
    @(posedge clk);
    #1;
    t = cyc;
    bus.start_ldb = 1'b0;
    bus.start_stb = 1'b0;
    bus.bm_sel    = 2'($urandom);
    bus.base_addr = 16'($urandom);
  endtask

  task automatic count_events(input int lo, input int hi, output int nw, output int ws,
                              output int nd, output int ds);
    nw = 0; ws = -1; nd = 0; ds = -1;
    foreach (wbm_q[i]) if (wbm_q[i].s > lo && wbm_q[i].s <= hi) begin
      nw++; ws = wbm_q[i].s; last_wd = wbm_q[i].d;
    end
    foreach (done_q[i]) if (done_q[i] > lo && done_q[i] <= hi) begin
      nd++; ds = done_q[i];
    end
  endtask

  task automatic check_load(input int t, input logic [1:0] sel, input logic [15:0] base,
                            input logic [BW-1:0] exp);
    int nrd = 0, bad = 0, nbad = 0, nw, ws, nd, ds;
    logic [1:0] wa = 2'd0;
    foreach (mem_q[i]) if (mem_q[i].s > t && mem_q[i].s <= t + 99) begin
      if (mem_q[i].we || mem_q[i].s != t + 1 + nrd || mem_q[i].addr != base + 16'(nrd)) bad++;
      nrd++;
    end
    last_wd = '0;
    count_events(t, t + 99, nw, ws, nd, ds);
    foreach (wbm_q[i]) if (wbm_q[i].s > t && wbm_q[i].s <= t + 99) wa = wbm_q[i].a;
    for (int w = 0; w < WORDS; w++) if (last_wd[16*w +: 16] !== exp[16*w +: 16]) nbad++;
    chk("ld_reads", 64'(nrd), 64'd96);
    chk("ld_addr_seq", 64'(bad), 64'd0);
    chk("ld_wbm_count", 64'(nw), 64'd1);
    chk("ld_wbm_time", 64'(ws - t), 64'd98);
    chk("ld_wbm_addr", 64'(wa), 64'(sel));
    chk("ld_wbm_data_bad_words", 64'(nbad), 64'd0);
    chk("ld_done_count", 64'(nd), 64'd1);
    chk("ld_done_time", 64'(ds - t), 64'd98);
  endtask

  task automatic check_store(input int t, input logic [15:0] base, input logic [BW-1:0] rbm);
    int nwr = 0, bad = 0, nw, ws, nd, ds;
    foreach (mem_q[i]) if (mem_q[i].s > t && mem_q[i].s <= t + 98) begin
      if (!mem_q[i].we || mem_q[i].s != t + 1 + nwr || mem_q[i].addr != base + 16'(nwr) ||
          mem_q[i].data !== rbm[16*nwr +: 16]) bad++;
      nwr++;
    end
    count_events(t, t + 98, nw, ws, nd, ds);
    chk("st_writes", 64'(nwr), 64'd96);
    chk("st_write_seq", 64'(bad), 64'd0);
    chk("st_no_wbm", 64'(nw), 64'd0);
    chk("st_done_count", 64'(nd), 64'd1);
    chk("st_done_time", 64'(ds - t), 64'd97);
    for (int w = 0; w < WORDS; w++) ref_mem[base + 16'(w)] = rbm[16*w +: 16];
  endtask

  task automatic do_load(input logic [1:0] sel, input logic [15:0] base);
    int t;
    logic [BW-1:0] exp;
    exp = ref_bitmap(base);
    start_op(1'b1, 1'b0, sel, base, rand_bm(), t);
    wait_until(t + 101);
    check_load(t, sel, base, exp);
  endtask

  task automatic do_store(input logic [1:0] sel, input logic [15:0] base, input logic [BW-1:0] rbm);
    int t;
    start_op(1'b0, 1'b1, sel, base, rbm, t);
    wait_until(t + 4);
    bus.rbm_data = ~rbm;
    wait_until(t + 100);
    check_store(t, base, rbm);
  endtask

  initial begin
    int t, t2, nw, ws, nd, ds, nz;
    logic [BW-1:0] pat;
    logic [15:0] b;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);
    rst_n = 1'b0;
    bus.start_ldb = 1'b0; bus.start_stb = 1'b0; bus.bm_sel = 2'd0;
    bus.base_addr = 16'h0000; bus.rbm_data = '0;
    repeat (3) @(posedge clk);
    #1;
    nz = 0;
    for (int w = 0; w < WORDS; w++) if (bus.wbm_data[16*w +: 16] !== 16'h0000) nz++;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_wbm_en", 64'(bus.wbm_en), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_wbm_addr", 64'(bus.wbm_addr), 64'd0);
    chk("rst_wbm_data_nonzero_words", 64'(nz), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load of the counting pattern at 0x0100 into register 2.
    do_load(2'd2, 16'h0100);
    chk("ld37_word0", 64'(last_wd[15:0]), 64'h0000);
    chk("ld37_word95", 64'(last_wd[1535:1520]), 64'h005F);

    // Store with rbm_data disturbed after accept, then read it back.
    for (int k = 0; k < WORDS; k++) pat[16*k +: 16] = 16'hA500 + 16'(k);
    do_store(2'd1, 16'h0200, pat);
    do_load(2'd3, 16'h0200);

    // Both starts together, plus a store pulse mid-load.
    b = 16'($urandom);
    start_op(1'b1, 1'b1, 2'd0, b, rand_bm(), t);
    wait_until(t + 9);
    @(negedge clk);
    bus.start_stb = 1'b1;
    @(posedge clk);
    #1;
    bus.start_stb = 1'b0;
    wait_until(t + 101);
    check_load(t, 2'd0, b, ref_bitmap(b));

    // Address wrap past 0xFFFF.
    do_load(2'd1, 16'hFFF0);

    // Reset during a load, then an immediate new load.
    start_op(1'b1, 1'b0, 2'd3, 16'h3000, '0, t);
    wait_until(t + 39);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_mem_en", 64'(bus.mem_en), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_mem_addr", 64'(bus.mem_addr), 64'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    b = 16'($urandom);
    start_op(1'b1, 1'b0, 2'd2, b, '0, t2);
    count_events(t, t2 + 1, nw, ws, nd, ds);
    chk("abort_no_wbm", 64'(nw), 64'd0);
    chk("abort_no_done", 64'(nd), 64'd0);
    wait_until(t2 + 101);
    check_load(t2, 2'd2, b, ref_bitmap(b));

    // Load followed by a store accepted in the single IDLE cycle after done.
    b = 16'($urandom);
    pat = rand_bm();
    start_op(1'b1, 1'b0, 2'd1, b, '0, t);
    wait_until(t + 97);
    chk("b2b_busy_commit", 64'(bus.busy), 64'd1);
    wait_until(t + 98);
    chk("b2b_busy_idle", 64'(bus.busy), 64'd0);
    start_op(1'b0, 1'b1, 2'd0, 16'h8000, pat, t2);
    chk("b2b_accept_gap", 64'(t2 - t), 64'd99);
    chk("b2b_busy_again", 64'(bus.busy), 64'd1);
    wait_until(t2 + 100);
    check_load(t, 2'd1, b, ref_bitmap(b));
    check_store(t2, 16'h8000, pat);
    do_load(2'd3, 16'h8000);

    // Randomized mix of transfers.
    for (int r = 0; r < 4; r++) begin
      b = 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        do_store(2'($urandom), b, rand_bm());
        do_load(2'($urandom), b);
      end else begin
        do_load(2'($urandom), b);
      end
    end

    if (n_pass + n_fail != n_checks) $display("check bookkeeping inconsistent");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
